// File: rtl/bus_control_sequencer.sv
// Timing/control sequencer for the basic computer: T0..T6 step counter, instruction
// decode, indirect-bit latch. Optional macro INDIRECT_EN enables the T3 indirect fetch.
module bus_control_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic        ac_neg,
  input  logic        ac_zero,
  input  logic        e_flag,
  input  logic        dr_zero,
  output logic [2:0]  bus_sel,
  output logic [6:0]  ld,
  output logic [6:0]  inc,
  output logic [6:0]  clr,
  output logic [2:0]  alu_op,
  output logic        e_clr,
  output logic        e_cmp,
  output logic        mem_wr,
  output logic [2:0]  sc,
  output logic        halted
);

  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SRC_NONE = SEL_W'(0);
  localparam logic [SEL_W-1:0] SRC_AR   = SEL_W'(1);
  localparam logic [SEL_W-1:0] SRC_PC   = SEL_W'(2);
  localparam logic [SEL_W-1:0] SRC_DR   = SEL_W'(3);
  localparam logic [SEL_W-1:0] SRC_AC   = SEL_W'(4);
  localparam logic [SEL_W-1:0] SRC_IR   = SEL_W'(5);
  localparam logic [SEL_W-1:0] SRC_MEM  = SEL_W'(7);

  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_LDA  = 3'd3;
  localparam logic [2:0] ALU_CMA  = 3'd4;
  localparam logic [2:0] ALU_CIR  = 3'd5;
  localparam logic [2:0] ALU_CIL  = 3'd6;

`ifdef INDIRECT_EN
  localparam logic IND_EN = 1'b1;
`else
  localparam logic IND_EN = 1'b0;
`endif

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} step_t;

  step_t      step_q, step_d;
  logic       i_q, i_d;
  logic       halted_q, halted_d;
  logic       active;
  logic       last_step;
  logic       halt_hit;
  logic [2:0] d_op;

  assign d_op   = ir[14:12];
  assign active = run & ~halted_q & rst_n;
  assign sc     = step_q;
  assign halted = halted_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q   <= T0;
      i_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      i_q      <= i_d;
      halted_q <= halted_d;
    end
  end

  // Step decode, control strobes and next state
  always_comb begin
    bus_sel   = SRC_NONE;
    ld        = '0;
    inc       = '0;
    clr       = '0;
    alu_op    = ALU_NONE;
    e_clr     = 1'b0;
    e_cmp     = 1'b0;
    mem_wr    = 1'b0;
    last_step = 1'b0;
    halt_hit  = 1'b0;
    step_d    = step_q;
    i_d       = i_q;
    halted_d  = halted_q;

    if (active) begin
      case (step_q)
        T0: begin
          bus_sel    = SRC_PC;
          ld[SRC_AR] = 1'b1;
        end
        T1: begin
          bus_sel     = SRC_MEM;
          ld[SRC_IR]  = 1'b1;
          inc[SRC_PC] = 1'b1;
        end
        T2: begin
          bus_sel    = SRC_IR;
          ld[SRC_AR] = 1'b1;
        end
        T3: begin
          if (d_op == 3'd7) begin
            last_step = 1'b1;
            // Register-reference: only the highest set bit of ir[11:0] acts
            if (!i_q) begin
              if      (ir[11]) clr[SRC_AC] = 1'b1;
              else if (ir[10]) e_clr       = 1'b1;
              else if (ir[9])  alu_op      = ALU_CMA;
              else if (ir[8])  e_cmp       = 1'b1;
              else if (ir[7])  alu_op      = ALU_CIR;
              else if (ir[6])  alu_op      = ALU_CIL;
              else if (ir[5])  inc[SRC_AC] = 1'b1;
              else if (ir[4])  inc[SRC_PC] = ~ac_neg;
              else if (ir[3])  inc[SRC_PC] = ac_neg;
              else if (ir[2])  inc[SRC_PC] = ac_zero;
              else if (ir[1])  inc[SRC_PC] = ~e_flag;
              else if (ir[0])  halt_hit    = 1'b1;
            end
          end else if (i_q) begin
            bus_sel    = SRC_MEM;
            ld[SRC_AR] = 1'b1;
          end
        end
        T4: begin
          case (d_op)
            3'd0, 3'd1, 3'd2, 3'd6: begin
              bus_sel    = SRC_MEM;
              ld[SRC_DR] = 1'b1;
            end
            3'd3: begin
              bus_sel   = SRC_AC;
              mem_wr    = 1'b1;
              last_step = 1'b1;
            end
            3'd4: begin
              bus_sel    = SRC_AR;
              ld[SRC_PC] = 1'b1;
              last_step  = 1'b1;
            end
            3'd5: begin
              bus_sel     = SRC_PC;
              mem_wr      = 1'b1;
              inc[SRC_AR] = 1'b1;
            end
            default: last_step = 1'b1;
          endcase
        end
        T5: begin
          case (d_op)
            3'd0: begin alu_op = ALU_AND; last_step = 1'b1; end
            3'd1: begin alu_op = ALU_ADD; last_step = 1'b1; end
            3'd2: begin alu_op = ALU_LDA; last_step = 1'b1; end
            3'd5: begin
              bus_sel    = SRC_AR;
              ld[SRC_PC] = 1'b1;
              last_step  = 1'b1;
            end
            3'd6:    inc[SRC_DR] = 1'b1;
            default: last_step   = 1'b1;
          endcase
        end
        T6: begin
          last_step = 1'b1;
          if (d_op == 3'd6) begin
            bus_sel     = SRC_DR;
            mem_wr      = 1'b1;
            inc[SRC_PC] = dr_zero;
          end
        end
        default: last_step = 1'b1;
      endcase

      step_d = last_step ? T0 : step_t'(step_q + 3'd1);
      if (step_q == T2) i_d = IND_EN & ir[15];
      if (halt_hit) halted_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Scoreboard bench for bus_control_sequencer: per-cycle expected control words are
// queued with the stimulus and compared on the falling edge.
module tb_bus_control_sequencer;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] ir;
  logic        ac_neg, ac_zero, e_flag, dr_zero;
  logic [2:0]  bus_sel;
  logic [6:0]  ld, inc, clr;
  logic [2:0]  alu_op;
  logic        e_clr, e_cmp, mem_wr;
  logic [2:0]  sc;
  logic        halted;

  logic [33:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  bus_control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir(ir),
    .ac_neg(ac_neg), .ac_zero(ac_zero), .e_flag(e_flag), .dr_zero(dr_zero),
    .bus_sel(bus_sel), .ld(ld), .inc(inc), .clr(clr), .alu_op(alu_op),
    .e_clr(e_clr), .e_cmp(e_cmp), .mem_wr(mem_wr), .sc(sc), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [33:0] obs = {bus_sel, ld, inc, clr, alu_op, e_clr, e_cmp, mem_wr, sc, halted};

  function automatic logic [33:0] mk(input logic [2:0] sel, input logic [6:0] l,
                                     input logic [6:0] i, input logic [6:0] c,
                                     input logic [2:0] alu, input logic ec,
                                     input logic ecm, input logic mw,
                                     input logic [2:0] s, input logic h);
    return {sel, l, i, c, alu, ec, ecm, mw, s, h};
  endfunction

  function automatic logic [33:0] z(input logic [2:0] s, input logic h);
    return mk(3'd0, 7'd0, 7'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, s, h);
  endfunction

  task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (bus,ld,inc,clr,alu,eclr,ecmp,mw,sc,halt)",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) check_eq(tag_q.pop_front(), obs, exp_q.pop_front());
  end

  task automatic step(input string tag, input logic [33:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    step({tag, "_t0"}, mk(3'd2, 7'b0000010, 7'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));
    step({tag, "_t1"}, mk(3'd7, 7'b0100000, 7'b0000100, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0));
    step({tag, "_t2"}, mk(3'd5, 7'b0000010, 7'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0));
  endtask

  task automatic isz(input string tag, input logic zero_hit);
    fetch(tag);
    step({tag, "_t3"}, z(3'd3, 1'b0));
    step({tag, "_t4"}, mk(3'd7, 7'b0001000, 7'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));
    step({tag, "_t5"}, mk(3'd0, 7'd0, 7'b0001000, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0));
    step({tag, "_t6"}, mk(3'd3, 7'd0, zero_hit ? 7'b0000100 : 7'd0, 7'd0, 3'd0,
                          1'b0, 1'b0, 1'b1, 3'd6, 1'b0));
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; ir = 16'h7800;
    ac_neg = 1'b0; ac_zero = 1'b0; e_flag = 1'b0; dr_zero = 1'b0;
    @(posedge clk);
    #1;

    // Reset: no strobes even with run high; then T0 gated by run low
    step("rst_run1", z(3'd0, 1'b0));
    rst_n = 1'b1; run = 1'b0;
    step("idle_run0_a", z(3'd0, 1'b0));
    step("idle_run0_b", z(3'd0, 1'b0));
    run = 1'b1;

    // CLA
    fetch("cla");
    step("cla_t3", mk(3'd0, 7'd0, 7'd0, 7'b0010000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0));

    // ADD direct
    ir = 16'h1123;
    fetch("add");
    step("add_t3", z(3'd3, 1'b0));
    step("add_t4", mk(3'd7, 7'b0001000, 7'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));
    step("add_t5", mk(3'd0, 7'd0, 7'd0, 7'd0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0));

    // ADD with I=1
    ir = 16'h9123;
    fetch("iadd");
`ifdef INDIRECT_EN
    step("iadd_t3", mk(3'd7, 7'b0000010, 7'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0));
`else
    step("iadd_t3", z(3'd3, 1'b0));
`endif
    step("iadd_t4", mk(3'd7, 7'b0001000, 7'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));
    step("iadd_t5", mk(3'd0, 7'd0, 7'd0, 7'd0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0));

    // ISZ with and without DR zero
    ir = 16'h6050; dr_zero = 1'b1;
    isz("isz_z", 1'b1);
    dr_zero = 1'b0;
    isz("isz_nz", 1'b0);

    // SZA both ways
    ir = 16'h7004; ac_zero = 1'b1;
    fetch("sza1");
    step("sza1_t3", mk(3'd0, 7'd0, 7'b0000100, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0));
    ac_zero = 1'b0;
    fetch("sza0");
    step("sza0_t3", z(3'd3, 1'b0));

    // CMA, and INC+HLT bits together: highest bit wins, no halt
    ir = 16'h7200;
    fetch("cma");
    step("cma_t3", mk(3'd0, 7'd0, 7'd0, 7'd0, 3'd4, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0));
    ir = 16'h7021;
    fetch("inc_hlt");
    step("inc_hlt_t3", mk(3'd0, 7'd0, 7'b0010000, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0));

    // STA and BUN
    ir = 16'h3055;
    fetch("sta");
    step("sta_t3", z(3'd3, 1'b0));
    step("sta_t4", mk(3'd4, 7'd0, 7'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0));
    ir = 16'h4055;
    fetch("bun");
    step("bun_t3", z(3'd3, 1'b0));
    step("bun_t4", mk(3'd1, 7'b0000100, 7'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0));

    // BSA with run dropped at T4
    ir = 16'h5123;
    fetch("bsa");
    step("bsa_t3", z(3'd3, 1'b0));
    run = 1'b0;
    for (int k = 0; k < 3; k++) step("bsa_paused", z(3'd4, 1'b0));
    run = 1'b1;
    step("bsa_t4", mk(3'd2, 7'd0, 7'b0000010, 7'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0));
    step("bsa_t5", mk(3'd1, 7'b0000100, 7'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0));

    // Reset aborting an instruction at T4
    ir = 16'h1123;
    fetch("abort");
    step("abort_t3", z(3'd3, 1'b0));
    rst_n = 1'b0;
    step("abort_rst", z(3'd0, 1'b0));
    rst_n = 1'b1;

    // HLT: sticky until reset
    ir = 16'h7001;
    fetch("hlt");
    step("hlt_t3", z(3'd3, 1'b0));
    for (int k = 0; k < 10; k++) step("halted_hold", z(3'd0, 1'b1));
    rst_n = 1'b0;
    step("halt_rst", z(3'd0, 1'b0));
    rst_n = 1'b1;
    ir = 16'h7800;
    fetch("post_rst");
    step("post_rst_t3", mk(3'd0, 7'd0, 7'd0, 7'b0010000, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0));
    step("post_rst_wrap", mk(3'd2, 7'b0000010, 7'd0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0));

    @(negedge clk);
    #1;
    check_eq("sb_empty", 34'(exp_q.size()), 34'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
